// File: rtl/alu_operand_stage.sv
// Decode/operand-fetch stage ahead of the ALU: regfile read with writeback bypass, busy-bit hazard stall.
// Latency: instr to output slot is 1 cycle; sustains 1 op/cycle when the slot drains as it refills.
// Backpressure: slot holds while out_ready=0; in_ready drops on a full, unconsumed slot or a busy register.
module alu_operand_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [31:0]           instr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     In1,
    output logic [DATA_W-1:0]     In2,
    output logic [3:0]            opcode,
    output logic [4:0]            SR_Bit,
    output logic [2:0]            SR_Cont,
    output logic [REG_ADDR_W-1:0] out_rd,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_W-1:0]     wb_data
);

    localparam int NUM_REGS = 2 ** REG_ADDR_W;

    logic [DATA_W-1:0]     regs [NUM_REGS];
    logic [NUM_REGS-1:0]   busy;
    logic [NUM_REGS-1:0]   busy_next;

    logic [3:0]            f_op;
    logic [REG_ADDR_W-1:0] f_rd;
    logic [REG_ADDR_W-1:0] f_rs1;
    logic [REG_ADDR_W-1:0] f_rs2;
    logic [2:0]            f_sc;
    logic [4:0]            f_sb;
    logic                  unused_rsvd;

    logic [DATA_W-1:0]     op1;
    logic [DATA_W-1:0]     op2;
    logic                  hz;
    logic                  accept;
    logic                  wb_live;

    assign f_op        = instr[31:28];
    assign f_rd        = instr[23 +: REG_ADDR_W];
    assign f_rs1       = instr[18 +: REG_ADDR_W];
    assign f_rs2       = instr[13 +: REG_ADDR_W];
    assign f_sc        = instr[12:10];
    assign f_sb        = instr[9:5];
    assign unused_rsvd = ^instr[4:0];

    assign wb_live = wb_en && (wb_addr != '0);

    // A busy term is ignored for reg 0 and when its writeback lands this cycle.
    function automatic logic blocks(
        input logic [REG_ADDR_W-1:0] idx,
        input logic [NUM_REGS-1:0]   bvec,
        input logic                  wen,
        input logic [REG_ADDR_W-1:0] waddr
    );
        return (idx != '0) && bvec[idx] && !(wen && (waddr == idx));
    endfunction

    always_comb begin
        hz = blocks(f_rs1, busy, wb_en, wb_addr)
           | blocks(f_rs2, busy, wb_en, wb_addr)
           | blocks(f_rd,  busy, wb_en, wb_addr);
    end

    assign in_ready = !hz && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        op1 = regs[f_rs1];
        if (f_rs1 == '0) begin
            op1 = '0;
        end else if (wb_en && (wb_addr == f_rs1)) begin
            op1 = wb_data;
        end
        op2 = regs[f_rs2];
        if (f_rs2 == '0) begin
            op2 = '0;
        end else if (wb_en && (wb_addr == f_rs2)) begin
            op2 = wb_data;
        end
    end

    // Clear first so a same-cycle issue to the same register keeps it busy.
    always_comb begin
        busy_next = busy;
        if (wb_live) begin
            busy_next[wb_addr] = 1'b0;
        end
        if (accept && (f_rd != '0)) begin
            busy_next[f_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_live) begin
            regs[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy      <= '0;
            out_valid <= 1'b0;
            In1       <= '0;
            In2       <= '0;
            opcode    <= '0;
            SR_Bit    <= '0;
            SR_Cont   <= '0;
            out_rd    <= '0;
        end else begin
            busy <= busy_next;
            if (accept) begin
                out_valid <= 1'b1;
                In1       <= op1;
                In2       <= op2;
                opcode    <= f_op;
                SR_Bit    <= f_sb;
                SR_Cont   <= f_sc;
                out_rd    <= f_rd;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: expected slot contents are queued at issue and checked by a monitor on consume.
module tb_alu_operand_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] In1;
    logic [31:0] In2;
    logic [3:0]  opcode;
    logic [4:0]  SR_Bit;
    logic [2:0]  SR_Cont;
    logic [4:0]  out_rd;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    typedef struct packed {
        logic [31:0] in1;
        logic [31:0] in2;
        logic [3:0]  op;
        logic [4:0]  sb;
        logic [2:0]  sc;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    alu_operand_stage #(.DATA_W(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .In1(In1), .In2(In2), .opcode(opcode), .SR_Bit(SR_Bit), .SR_Cont(SR_Cont),
        .out_rd(out_rd),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] sc, input logic [4:0] sb);
        return {op, rd, rs1, rs2, sc, sb, 5'b0};
    endfunction

    function automatic exp_t ex(input logic [31:0] i1, input logic [31:0] i2, input logic [3:0] op,
                                input logic [4:0] sb, input logic [2:0] sc, input logic [4:0] rd);
        exp_t e;
        e.in1 = i1; e.in2 = i2; e.op = op; e.sb = sb; e.sc = sc; e.rd = rd;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
        wb_en = en; wb_addr = a; wb_data = d;
    endtask

    // Monitor: every consumed slot must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: got In1=%0h In2=%0h rd=%0d, expected nothing",
                         In1, In2, out_rd);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                if ({In1, In2, opcode, SR_Bit, SR_Cont, out_rd} !== e) begin
                    errors++;
                    $display("FAIL slot: got In1=%0h In2=%0h op=%0h sb=%0d sc=%0d rd=%0d expected In1=%0h In2=%0h op=%0h sb=%0d sc=%0d rd=%0d",
                             In1, In2, opcode, SR_Bit, SR_Cont, out_rd,
                             e.in1, e.in2, e.op, e.sb, e.sc, e.rd);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; instr = '0; out_ready = 1'b1;
        wb(1'b0, 5'd0, 32'd0);

        // Reset
        tick(); tick();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_In1", In1, 32'd0);
        chk("rst_In2", In2, 32'd0);
        chk("rst_fields", {20'd0, opcode, SR_Bit, SR_Cont}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        rst = 1'b0;

        // Basic issue
        wb(1'b1, 5'd1, 32'd15);
        tick();
        wb(1'b1, 5'd2, 32'd20);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        instr = mk(4'd0, 5'd3, 5'd1, 5'd2, 3'd0, 5'd0); in_valid = 1'b1;
        #1 chk("basic_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'd15, 32'd20, 4'd0, 5'd0, 3'd0, 5'd3));
        tick();
        chk("basic_out_valid", {31'd0, out_valid}, 32'd1);

        // RAW stall on r3, released by writeback with bypass
        instr = mk(4'd1, 5'd4, 5'd3, 5'd0, 3'd2, 5'd7);
        #1 chk("raw_stall_0", {31'd0, in_ready}, 32'd0);
        tick();
        chk("raw_stall_1", {31'd0, in_ready}, 32'd0);
        tick();
        wb(1'b1, 5'd3, 32'd35);
        #1 chk("raw_release", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'd35, 32'd0, 4'd1, 5'd7, 3'd2, 5'd4));
        tick();
        wb(1'b0, 5'd0, 32'd0);

        // Backpressure: slot holds the r4 op
        out_ready = 1'b0;
        instr = mk(4'd2, 5'd6, 5'd1, 5'd2, 3'd1, 5'd3);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_In1", In1, 32'd35);
            chk("bp_hold", {20'd0, opcode, SR_Bit, SR_Cont}, {20'd0, 4'd1, 5'd7, 3'd2});
            chk("bp_out_rd", {27'd0, out_rd}, 32'd4);
            tick();
        end
        out_ready = 1'b1;
        #1 chk("bp_release", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'd15, 32'd20, 4'd2, 5'd3, 3'd1, 5'd6));
        tick();
        in_valid = 1'b0;

        // Register 0: write dropped, never stalls
        wb(1'b1, 5'd0, 32'hDEAD);
        tick();
        wb(1'b0, 5'd0, 32'd0);
        instr = mk(4'd3, 5'd0, 5'd0, 5'd0, 3'd0, 5'd0); in_valid = 1'b1;
        #1 chk("r0_in_ready", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'd0, 32'd0, 4'd3, 5'd0, 3'd0, 5'd0));
        tick();
        instr = mk(4'd3, 5'd0, 5'd6, 5'd0, 3'd0, 5'd0);
        #1 chk("busy6_kept", {31'd0, in_ready}, 32'd0);
        instr = mk(4'd3, 5'd0, 5'd0, 5'd4, 3'd0, 5'd0);
        #1 chk("busy4_kept", {31'd0, in_ready}, 32'd0);
        instr = mk(4'd3, 5'd6, 5'd0, 5'd0, 3'd0, 5'd0);
        #1 chk("waw_stall", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        tick();

        // Reset mid-operation: slot and busy[5] dropped, then immediate issue
        instr = mk(4'd4, 5'd5, 5'd1, 5'd2, 3'd0, 5'd0); in_valid = 1'b1;
        #1 chk("r5_issue", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        chk("r5_slot_full", {31'd0, out_valid}, 32'd1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_In1", In1, 32'd0);
        chk("midrst_out_rd", {27'd0, out_rd}, 32'd0);
        out_ready = 1'b1;
        wb(1'b1, 5'd1, 32'hABCD);
        instr = mk(4'd5, 5'd7, 5'd5, 5'd1, 3'd4, 5'd9); in_valid = 1'b1;
        #1 chk("post_rst_accept", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'd0, 32'hABCD, 4'd5, 5'd9, 3'd4, 5'd7));
        tick();
        wb(1'b0, 5'd0, 32'd0);
        instr = mk(4'd6, 5'd0, 5'd1, 5'd2, 3'd0, 5'd0);
        #1 chk("post_rst_issue2", {31'd0, in_ready}, 32'd1);
        sb_q.push_back(ex(32'hABCD, 32'd0, 4'd6, 5'd0, 3'd0, 5'd0));
        tick();
        in_valid = 1'b0;

        tick(); tick(); tick();
        chk("queue_drained", sb_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
